// File: rtl/dsp_dmem_pkg.sv
// rtl/dsp_dmem_pkg.sv - shared constants, clear-FSM states and byte-merge helper for dsp_data_mem
package dsp_dmem_pkg;

   // Legal range of the read-latency pipeline depth
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Widest word the merge helper handles; callers zero-extend and truncate
   localparam int DMEM_MAX_DATA_W = 256;
   localparam int DMEM_MAX_BE_W   = DMEM_MAX_DATA_W / 8;

   // States of the optional post-reset clear sequencer
   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_e;

   // Replace the bytes of old_word selected by be with the matching bytes of new_word
   function automatic logic [DMEM_MAX_DATA_W-1:0] be_merge(
      input logic [DMEM_MAX_DATA_W-1:0] old_word,
      input logic [DMEM_MAX_DATA_W-1:0] new_word,
      input logic [DMEM_MAX_BE_W-1:0]   be
   );
      logic [DMEM_MAX_DATA_W-1:0] mask;
      for (int i = 0; i < DMEM_MAX_BE_W; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return (old_word & ~mask) | (new_word & mask);
   endfunction

endpackage

// File: rtl/dsp_dmem_rd_pipe.sv
// rtl/dsp_dmem_rd_pipe.sv - RD_LAT-deep valid/data delay line with synchronous flush
module dsp_dmem_rd_pipe
   import dsp_dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [RD_LAT-1:0] vld_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];

   // Shift valid every cycle; data only advances with a valid so the last stage holds between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= valid_i;
         if (valid_i) begin
            dat_q[0] <= data_i;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign valid_o = vld_q[RD_LAT-1];
   assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/dsp_data_mem.sv
// rtl/dsp_data_mem.sv - byte-enabled data memory with read pipeline and wrap pointer; optional DMEM_CLEAR_ON_RESET_EN
module dsp_data_mem
   import dsp_dmem_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 256,
   parameter  int RD_LAT = 1,
   localparam int ADDR_W = $clog2(DEPTH)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic                req_inc,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                ptr_clr,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0]   ptr,
   output logic                busy
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_w;
   logic              acc;
   logic [ADDR_W-1:0] eff_addr;
   logic              in_range;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] merged_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign req_ready = !rst && !busy_w;
   assign acc       = req_valid && req_ready;
   assign eff_addr  = req_inc ? ptr_q : req_addr;

   // DEPTH need not be a power of two, so the top of the address space can be unbacked
   assign in_range  = 32'(eff_addr) < 32'(DEPTH);
   assign rd_word   = in_range ? mem_q[eff_addr] : '0;

   assign merged_word = DATA_W'(be_merge(DMEM_MAX_DATA_W'(rd_word),
                                         DMEM_MAX_DATA_W'(req_wdata),
                                         DMEM_MAX_BE_W'(req_be)));

   // Pointer post-increments with wrap; a clear wins but the current access still used the old value
   always_comb begin
      ptr_d = ptr_q;
      if (acc && req_inc) begin
         ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
      end
      if (ptr_clr) begin
         ptr_d = '0;
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`ifdef DMEM_CLEAR_ON_RESET_EN
   clr_state_e        st_q, st_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_we;

   // Clear sequencer state; reset always (re)starts a full sweep from word 0
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= CLR_CLEAR;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // Zero one word per cycle, leave after the last word
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      clr_we = 1'b0;
      case (st_q)
         CLR_CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               st_d  = CLR_IDLE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            st_d = CLR_IDLE;
         end
      endcase
   end

   assign busy_w = (st_q == CLR_CLEAR);
`else
   assign busy_w = 1'b0;
`endif

   // Single write port: clear sweep when active, otherwise the accepted in-range write
   always_comb begin
      mem_we    = acc && req_we && in_range;
      mem_waddr = eff_addr;
      mem_wdata = merged_word;
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q;
         mem_wdata = '0;
      end
`endif
   end

   // Storage array; no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   dsp_dmem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .valid_i (acc && !req_we),
      .data_i  (rd_word),
      .valid_o (rsp_valid),
      .data_o  (rsp_rdata)
   );

   assign ptr  = ptr_q;
   assign busy = busy_w;

endmodule

// File: tb/tb_dsp_data_mem.sv
// tb/tb_dsp_data_mem.sv - scoreboard bench for dsp_data_mem (honours DMEM_CLEAR_ON_RESET_EN)
module tb_dsp_data_mem;

   localparam int DW     = 32;
   localparam int DEPTH  = 200;
   localparam int RD_LAT = 2;
   localparam int AW     = $clog2(DEPTH);

   logic          clk;
   logic          rst;
   logic          req_valid, req_ready, req_we, req_inc, ptr_clr;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_be;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ptr;
   logic          busy;

   dsp_data_mem #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_inc   (req_inc),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .ptr_clr   (ptr_clr),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ptr       (ptr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mmem [DEPTH];
   int          mptr;
   logic [31:0] mlast;
   int          clr_left;
   int          cyc;
   bit          armed;
   int          n_cmp;
   int          n_err;

   function automatic bit mbusy();
      return clr_left > 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the reference model at the edge
   task automatic step(input bit v, input bit we, input bit inc, input bit clr, input bit r,
                       input int addr, input logic [3:0] be, input logic [31:0] wd);
      bit   ready;
      int   a;
      exp_t e;
      req_valid = v;  req_we = we;  req_inc = inc;  ptr_clr = clr;  rst = r;
      req_addr  = AW'(addr);  req_be = be;  req_wdata = wd;
      @(posedge clk);
      cyc++;
      ready = !r && !mbusy();
      if (r) begin
         sbq.delete();
         mptr  = 0;
         mlast = 0;
`ifdef DMEM_CLEAR_ON_RESET_EN
         clr_left = DEPTH;
`endif
      end else begin
         if (clr_left > 0) begin
            mmem[DEPTH - clr_left] = 0;
            clr_left--;
         end
         if (v && ready) begin
            a = inc ? mptr : addr;
            if (!we) begin
               e.due  = cyc + RD_LAT - 1;
               e.data = (a < DEPTH) ? mmem[a] : 32'h0;
               sbq.push_back(e);
            end else if (a < DEPTH) begin
               for (int i = 0; i < 4; i++)
                  if (be[i]) mmem[a] = (mmem[a] & ~(32'hFF << (8*i))) | (wd & (32'hFF << (8*i)));
            end
            if (inc) mptr = (mptr == DEPTH - 1) ? 0 : mptr + 1;
         end
         if (clr) mptr = 0;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
   endtask

   task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
      step(1, 1, 0, 0, 0, addr, be, d);
   endtask

   task automatic rd(input int addr);
      step(1, 0, 0, 0, 0, addr, 4'h0, 32'h0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < DEPTH + 8 && mbusy(); i++) idle();
   endtask

   // Monitor: continuous output checks and scoreboard pops, away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         check("req_ready", 64'(req_ready), 64'(!rst && !mbusy()));
         check("busy", 64'(busy), 64'(mbusy()));
         check("ptr", 64'(ptr), 64'(mptr));
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
               e = sbq.pop_front();
               check("rsp_cycle", 64'(cyc), 64'(e.due));
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
               mlast = e.data;
            end
         end else begin
            check("rsp_hold", 64'(rsp_rdata), 64'(mlast));
            if (sbq.size() != 0 && sbq[0].due <= cyc) begin
               e = sbq.pop_front();
               check("rsp_missing", 64'(rsp_valid), 64'd1);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;  n_err = 0;  cyc = 0;  armed = 0;
      mptr = 0;  mlast = 0;  clr_left = 0;
      req_valid = 0;  req_we = 0;  req_inc = 0;  ptr_clr = 0;  rst = 1;
      req_addr = '0;  req_be = '0;  req_wdata = '0;
      @(negedge clk);
      #1;
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      armed = 1;
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      wait_ready();

      // Full write then partial-byte write over the same word, each read back immediately
      wr(5, 32'h12345678, 4'b1111);
      rd(5);
      wr(5, 32'hAABBCCDD, 4'b0101);
      rd(5);
      wr(5, 32'hFFFFFFFF, 4'b0000);
      rd(5);

      // Pointer wrap: DEPTH+2 incrementing writes of the index
      step(0, 0, 0, 1, 0, 0, 4'h0, 32'h0);
      for (int i = 0; i < DEPTH + 2; i++) step(1, 1, 1, 0, 0, 0, 4'hF, 32'(i));
      step(0, 0, 0, 1, 0, 0, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 4'h0, 32'h0);
      rd(0);
      rd(1);
      rd(DEPTH - 1);

      // Out-of-range write is dropped, read returns zero, last word untouched
      wr(210, 32'hDEADBEEF, 4'hF);
      rd(210);
      rd(DEPTH - 1);

      // Increment together with pointer clear uses the old pointer
      step(1, 0, 1, 1, 0, 0, 4'h0, 32'h0);
      step(1, 1, 1, 1, 0, 0, 4'hF, 32'hCAFE0001);
      rd(0);

      // Back-to-back reads then reset the cycle after the last accept
      rd(3);
      rd(4);
      rd(6);
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) idle();
      wait_ready();

`ifdef DMEM_CLEAR_ON_RESET_EN
      // Reset mid-clear restarts the full sweep
      wr(7, 32'h55AA55AA, 4'hF);
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      for (int i = 0; i < DEPTH / 2; i++) idle();
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      wait_ready();
      rd(7);
      rd(0);
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(3) != 0, 1'($urandom), $urandom_range(3) == 0,
              $urandom_range(15) == 0, $urandom_range(149) == 0,
              $urandom_range(DEPTH + 20), 4'($urandom), $urandom);
      end

      for (int i = 0; i < RD_LAT + 4; i++) idle();
      check("drain", 64'(sbq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
